// File: rtl/de_md_reg_pkg.sv
// Shared constants for the D->E register: MDU opcode encodings, fixed PCs,
// exception codes and the MD-class opcode decode helpers.
package de_md_reg_pkg;

    localparam logic [3:0] MDU_NONE  = 4'd0;
    localparam logic [3:0] MDU_MULT  = 4'd1;
    localparam logic [3:0] MDU_MULTU = 4'd2;
    localparam logic [3:0] MDU_DIV   = 4'd3;
    localparam logic [3:0] MDU_DIVU  = 4'd4;
    localparam logic [3:0] MDU_MFHI  = 4'd5;
    localparam logic [3:0] MDU_MFLO  = 4'd6;
    localparam logic [3:0] MDU_MTHI  = 4'd7;
    localparam logic [3:0] MDU_MTLO  = 4'd8;

    localparam logic [31:0] RESET_PC   = 32'h0000_3000;
    localparam logic [31:0] HANDLER_PC = 32'h0000_4180;

    localparam logic [4:0] EXC_NONE = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    // Any opcode that touches HI/LO or the MDU pipeline.
    function automatic logic mdu_is_md(input logic [31:0] op);
        return (op >= 32'(MDU_MULT)) && (op <= 32'(MDU_MTLO));
    endfunction

    // Opcodes that launch a multi-cycle MDU operation.
    function automatic logic mdu_is_start(input logic [31:0] op);
        return (op >= 32'(MDU_MULT)) && (op <= 32'(MDU_DIVU));
    endfunction

endpackage

// File: rtl/de_md_reg_md_stall_unit.sv
// Multiply/divide structural stall term plus a saturating count of MD-stall cycles.
module md_stall_unit #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req,
    input  logic             is_md,
    input  logic             e_start,
    input  logic             e_busy,
    output logic             md_stall,
    output logic [CNT_W-1:0] md_stall_cnt
);

    logic [CNT_W-1:0] cnt_reg;

    // Busy is still low during the MDU's Start cycle, so the in-flight Start counts too.
    assign md_stall     = is_md && (e_start || e_busy);
    assign md_stall_cnt = cnt_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_reg <= '0;
        end else if (md_stall && !req && (cnt_reg != {CNT_W{1'b1}})) begin
            cnt_reg <= cnt_reg + CNT_W'(1);
        end
    end

endmodule

// File: rtl/de_md_reg.sv
// D->E pipeline register in front of the MDU: loads, bubbles on stall,
// flushes to the handler on req, and registers the MDU Start pulse.
module de_md_reg
    import de_md_reg_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int MDUOP_W = 4,
    parameter int CNT_W   = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req,
    input  logic               hazard_stall,
    input  logic               e_busy,
    input  logic [DATA_W-1:0]  d_pc,
    input  logic [DATA_W-1:0]  d_instr,
    input  logic [DATA_W-1:0]  d_rs_data,
    input  logic [DATA_W-1:0]  d_rt_data,
    input  logic [DATA_W-1:0]  d_imm32,
    input  logic [MDUOP_W-1:0] d_mduop,
    input  logic [4:0]         d_wa,
    input  logic [1:0]         d_tnew,
    input  logic [4:0]         d_exccode,
    input  logic               d_bd,
    output logic [DATA_W-1:0]  e_pc,
    output logic [DATA_W-1:0]  e_instr,
    output logic [DATA_W-1:0]  e_rs_data,
    output logic [DATA_W-1:0]  e_rt_data,
    output logic [DATA_W-1:0]  e_imm32,
    output logic [MDUOP_W-1:0] e_mduop,
    output logic [4:0]         e_wa,
    output logic [1:0]         e_tnew,
    output logic [4:0]         e_exccode,
    output logic               e_bd,
    output logic               e_start,
    output logic               md_stall,
    output logic               stall,
    output logic [CNT_W-1:0]   md_stall_cnt
);

    logic [DATA_W-1:0]  e_pc_reg, e_instr_reg, e_rs_data_reg, e_rt_data_reg, e_imm32_reg;
    logic [MDUOP_W-1:0] e_mduop_reg;
    logic [4:0]         e_wa_reg, e_exccode_reg;
    logic [1:0]         e_tnew_reg;
    logic               e_bd_reg, e_start_reg;
    logic               is_md, is_start;

    assign is_md    = mdu_is_md(32'(d_mduop));
    assign is_start = mdu_is_start(32'(d_mduop));
    assign stall    = md_stall | hazard_stall;

    md_stall_unit #(.CNT_W(CNT_W)) u_md_stall_unit (
        .clk          (clk),
        .reset        (reset),
        .req          (req),
        .is_md        (is_md),
        .e_start      (e_start_reg),
        .e_busy       (e_busy),
        .md_stall     (md_stall),
        .md_stall_cnt (md_stall_cnt)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            e_pc_reg      <= DATA_W'(RESET_PC);
            e_instr_reg   <= '0;
            e_rs_data_reg <= '0;
            e_rt_data_reg <= '0;
            e_imm32_reg   <= '0;
            e_mduop_reg   <= MDUOP_W'(MDU_NONE);
            e_wa_reg      <= '0;
            e_tnew_reg    <= '0;
            e_exccode_reg <= EXC_NONE;
            e_bd_reg      <= 1'b0;
            e_start_reg   <= 1'b0;
        end else if (req) begin
            e_pc_reg      <= DATA_W'(HANDLER_PC);
            e_instr_reg   <= '0;
            e_rs_data_reg <= '0;
            e_rt_data_reg <= '0;
            e_imm32_reg   <= '0;
            e_mduop_reg   <= MDUOP_W'(MDU_NONE);
            e_wa_reg      <= '0;
            e_tnew_reg    <= '0;
            e_exccode_reg <= EXC_NONE;
            e_bd_reg      <= 1'b0;
            e_start_reg   <= 1'b0;
        end else if (stall) begin
            // Bubble keeps PC and BD so EPC is right if an interrupt lands on it.
            e_pc_reg      <= d_pc;
            e_instr_reg   <= '0;
            e_rs_data_reg <= '0;
            e_rt_data_reg <= '0;
            e_imm32_reg   <= '0;
            e_mduop_reg   <= MDUOP_W'(MDU_NONE);
            e_wa_reg      <= '0;
            e_tnew_reg    <= '0;
            e_exccode_reg <= EXC_NONE;
            e_bd_reg      <= d_bd;
            e_start_reg   <= 1'b0;
        end else begin
            e_pc_reg      <= d_pc;
            e_instr_reg   <= d_instr;
            e_rs_data_reg <= d_rs_data;
            e_rt_data_reg <= d_rt_data;
            e_imm32_reg   <= d_imm32;
            e_mduop_reg   <= d_mduop;
            e_wa_reg      <= d_wa;
            e_tnew_reg    <= d_tnew;
            e_exccode_reg <= d_exccode;
            e_bd_reg      <= d_bd;
            e_start_reg   <= is_start;
        end
    end

    assign e_pc      = e_pc_reg;
    assign e_instr   = e_instr_reg;
    assign e_rs_data = e_rs_data_reg;
    assign e_rt_data = e_rt_data_reg;
    assign e_imm32   = e_imm32_reg;
    assign e_mduop   = e_mduop_reg;
    assign e_wa      = e_wa_reg;
    assign e_tnew    = e_tnew_reg;
    assign e_exccode = e_exccode_reg;
    assign e_bd      = e_bd_reg;
    assign e_start   = e_start_reg;

endmodule

// File: tb/tb_de_md_reg.sv
// Directed vector bench for de_md_reg: table of per-cycle stimulus and expected
// E-stage state, plus hand sequences for counter saturation and reset mid-op.
module tb_de_md_reg;

    localparam logic [31:0] MULT = 32'h0085_0018;
    localparam logic [31:0] MFHI = 32'h0000_1010;
    localparam logic [31:0] MFLO = 32'h0000_1812;
    localparam logic [31:0] ADDU = 32'h0085_1021;
    localparam logic [31:0] DIV  = 32'h0085_001A;
    localparam logic [31:0] DIVU = 32'h0085_001B;
    localparam logic [31:0] NOP  = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset, req, hazard_stall, e_busy;
    logic [31:0] d_pc, d_instr, d_rs_data, d_rt_data, d_imm32;
    logic [3:0]  d_mduop;
    logic [4:0]  d_wa, d_exccode;
    logic [1:0]  d_tnew;
    logic        d_bd;
    logic [31:0] e_pc, e_instr, e_rs_data, e_rt_data, e_imm32;
    logic [3:0]  e_mduop;
    logic [4:0]  e_wa, e_exccode;
    logic [1:0]  e_tnew;
    logic        e_bd, e_start, md_stall, stall;
    logic [3:0]  md_stall_cnt;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    de_md_reg #(.DATA_W(32), .MDUOP_W(4), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .req(req), .hazard_stall(hazard_stall), .e_busy(e_busy),
        .d_pc(d_pc), .d_instr(d_instr), .d_rs_data(d_rs_data), .d_rt_data(d_rt_data),
        .d_imm32(d_imm32), .d_mduop(d_mduop), .d_wa(d_wa), .d_tnew(d_tnew),
        .d_exccode(d_exccode), .d_bd(d_bd),
        .e_pc(e_pc), .e_instr(e_instr), .e_rs_data(e_rs_data), .e_rt_data(e_rt_data),
        .e_imm32(e_imm32), .e_mduop(e_mduop), .e_wa(e_wa), .e_tnew(e_tnew),
        .e_exccode(e_exccode), .e_bd(e_bd), .e_start(e_start), .md_stall(md_stall),
        .stall(stall), .md_stall_cnt(md_stall_cnt)
    );

    typedef struct {
        logic        req, hz, busy;
        logic [31:0] pc, instr;
        logic [3:0]  op;
        logic        bd;
        logic        x_md, x_stall;
        logic [31:0] x_pc, x_instr;
        logic [3:0]  x_op;
        logic        x_start, x_bd;
        logic [3:0]  x_cnt;
    } vec_t;

    vec_t vecs[16];

    function automatic vec_t mk(logic rq, logic hz, logic busy, logic [31:0] pc,
                                logic [31:0] instr, logic [3:0] op, logic bd,
                                logic xmd, logic xst, logic [31:0] xpc, logic [31:0] xinstr,
                                logic [3:0] xop, logic xstart, logic xbd, logic [3:0] xcnt);
        vec_t v;
        v.req = rq; v.hz = hz; v.busy = busy; v.pc = pc; v.instr = instr; v.op = op; v.bd = bd;
        v.x_md = xmd; v.x_stall = xst; v.x_pc = xpc; v.x_instr = xinstr; v.x_op = xop;
        v.x_start = xstart; v.x_bd = xbd; v.x_cnt = xcnt;
        return v;
    endfunction

    // Operand fields are tied to the instruction word so an all-zero instr means all-zero fields.
    function automatic logic [31:0] f_rs(logic [31:0] i);  return {i[15:0], i[31:16]};  endfunction
    function automatic logic [31:0] f_rt(logic [31:0] i);  return i ^ {i[7:0], 24'h0}; endfunction
    function automatic logic [31:0] f_imm(logic [31:0] i); return i << 1;               endfunction
    function automatic logic [31:0] f_misc(logic [31:0] i);
        return {20'h0, i[15:11], i[17:16], i[10:6]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic drive_d(input logic [31:0] pc, input logic [31:0] instr,
                           input logic [3:0] op, input logic bd);
        d_pc = pc; d_instr = instr; d_mduop = op; d_bd = bd;
        d_rs_data = f_rs(instr); d_rt_data = f_rt(instr); d_imm32 = f_imm(instr);
        d_wa = instr[15:11]; d_tnew = instr[17:16]; d_exccode = instr[10:6];
    endtask

    task automatic chk_e(input string tag, input logic [31:0] xpc, input logic [31:0] xinstr,
                         input logic [3:0] xop, input logic xstart, input logic xbd,
                         input logic [3:0] xcnt);
        chk({tag, " e_pc"},    e_pc, xpc);
        chk({tag, " e_instr"}, e_instr, xinstr);
        chk({tag, " e_rs"},    e_rs_data, f_rs(xinstr));
        chk({tag, " e_rt"},    e_rt_data, f_rt(xinstr));
        chk({tag, " e_imm"},   e_imm32, f_imm(xinstr));
        chk({tag, " e_misc"},  {20'h0, e_wa, e_tnew, e_exccode}, f_misc(xinstr));
        chk({tag, " e_mduop"}, 32'(e_mduop), 32'(xop));
        chk({tag, " e_start"}, 32'(e_start), 32'(xstart));
        chk({tag, " e_bd"},    32'(e_bd), 32'(xbd));
        chk({tag, " cnt"},     32'(md_stall_cnt), 32'(xcnt));
    endtask

    initial begin
        vecs[0]  = mk(0,0,0, 32'h3000, MULT, 4'd1, 0,  0,0, 32'h3000, MULT, 4'd1, 1, 0, 4'd0);
        vecs[1]  = mk(0,0,0, 32'h3004, MFHI, 4'd5, 0,  1,1, 32'h3004, NOP,  4'd0, 0, 0, 4'd1);
        for (int k = 2; k <= 6; k++)
            vecs[k] = mk(0,0,1, 32'h3004, MFHI, 4'd5, 0, 1,1, 32'h3004, NOP, 4'd0, 0, 0, 4'(k));
        vecs[7]  = mk(0,0,0, 32'h3004, MFHI, 4'd5, 0,  0,0, 32'h3004, MFHI, 4'd5, 0, 0, 4'd6);
        vecs[8]  = mk(0,0,1, 32'h3008, ADDU, 4'd0, 0,  0,0, 32'h3008, ADDU, 4'd0, 0, 0, 4'd6);
        vecs[9]  = mk(0,1,0, 32'h3010, DIV,  4'd3, 1,  0,1, 32'h3010, NOP,  4'd0, 0, 1, 4'd6);
        vecs[10] = mk(0,1,0, 32'h3010, DIV,  4'd3, 1,  0,1, 32'h3010, NOP,  4'd0, 0, 1, 4'd6);
        vecs[11] = mk(0,1,0, 32'h3014, NOP,  4'd0, 0,  0,1, 32'h3014, NOP,  4'd0, 0, 0, 4'd6);
        vecs[12] = mk(0,0,0, 32'h3010, DIV,  4'd3, 0,  0,0, 32'h3010, DIV,  4'd3, 1, 0, 4'd6);
        vecs[13] = mk(1,1,1, 32'h3014, MFLO, 4'd6, 0,  1,1, 32'h4180, NOP,  4'd0, 0, 0, 4'd6);
        vecs[14] = mk(1,0,0, 32'h3018, DIVU, 4'd4, 0,  0,0, 32'h4180, NOP,  4'd0, 0, 0, 4'd6);
        vecs[15] = mk(0,0,0, 32'h301C, MFLO, 4'd6, 0,  0,0, 32'h301C, MFLO, 4'd6, 0, 0, 4'd6);

        reset = 1'b1; req = 1'b0; hazard_stall = 1'b0; e_busy = 1'b0;
        drive_d(32'h0, NOP, 4'd0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk_e("reset", 32'h3000, NOP, 4'd0, 1'b0, 1'b0, 4'd0);
        chk("reset stall", 32'(stall), 32'd0);
        chk("reset md_stall", 32'(md_stall), 32'd0);
        $display("reset: e_pc=%h cnt=%0d", e_pc, md_stall_cnt);
        reset = 1'b0;

        for (int i = 0; i < 16; i++) begin
            req = vecs[i].req; hazard_stall = vecs[i].hz; e_busy = vecs[i].busy;
            drive_d(vecs[i].pc, vecs[i].instr, vecs[i].op, vecs[i].bd);
            #2;
            chk($sformatf("v%0d md_stall", i), 32'(md_stall), 32'(vecs[i].x_md));
            chk($sformatf("v%0d stall", i), 32'(stall), 32'(vecs[i].x_stall));
            @(posedge clk); #1;
            chk_e($sformatf("v%0d", i), vecs[i].x_pc, vecs[i].x_instr, vecs[i].x_op,
                  vecs[i].x_start, vecs[i].x_bd, vecs[i].x_cnt);
            $display("v%0d: pc=%h instr=%h op=%0d -> e_pc=%h e_instr=%h e_mduop=%0d start=%b cnt=%0d",
                     i, vecs[i].pc, vecs[i].instr, vecs[i].op, e_pc, e_instr, e_mduop, e_start, md_stall_cnt);
        end

        // Counter saturation: 12 more MD stall cycles on top of 6 must stop at 15.
        req = 1'b0; hazard_stall = 1'b0; e_busy = 1'b0;
        drive_d(32'h3020, MULT, 4'd1, 1'b0);
        @(posedge clk); #1;
        chk("sat mult start", 32'(e_start), 32'd1);
        e_busy = 1'b1;
        drive_d(32'h3024, MFHI, 4'd5, 1'b0);
        for (int i = 0; i < 12; i++) begin
            #2;
            chk($sformatf("sat%0d md_stall", i), 32'(md_stall), 32'd1);
            @(posedge clk); #1;
            if (i == 7) chk("sat cnt 14", 32'(md_stall_cnt), 32'd14);
        end
        chk("sat cnt held", 32'(md_stall_cnt), 32'd15);
        chk("sat e_pc bubble", e_pc, 32'h3024);
        $display("saturate: cnt=%0d e_pc=%h", md_stall_cnt, e_pc);

        // Reset while a Start is in flight clears Start and the counter.
        e_busy = 1'b0;
        drive_d(32'h3028, MULT, 4'd2, 1'b0);
        @(posedge clk); #1;
        chk("rst-mid start", 32'(e_start), 32'd1);
        reset = 1'b1;
        drive_d(32'h302C, MFHI, 4'd5, 1'b0);
        @(posedge clk); #1;
        chk_e("rst-mid", 32'h3000, NOP, 4'd0, 1'b0, 1'b0, 4'd0);
        reset = 1'b0;
        #2;
        chk("post-rst md_stall", 32'(md_stall), 32'd0);
        @(posedge clk); #1;
        chk_e("post-rst", 32'h302C, MFHI, 4'd5, 1'b0, 1'b0, 4'd0);
        $display("reset mid-op: e_pc=%h e_mduop=%0d start=%b cnt=%0d", e_pc, e_mduop, e_start, md_stall_cnt);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
